// File: rtl/iiitb_bcd_pkg.sv
// Shared types and constants for the multi-digit BCD adder sequencer.
// Only the BCD_INVALID_CHECK_EN build of the top uses is_bcd().
package iiitb_bcd_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAdd,
    StDone
  } state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_ADJ = 4'd6;

  function automatic logic is_bcd(input logic [3:0] d);
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational single-digit BCD adder.
// Non-BCD digits follow the same rule: a 5-bit sum above 9 gets +6 and carry.
module bcd_digit_add
  import iiitb_bcd_pkg::*;
(
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  output logic [3:0] digit,
  output logic       cout
);

  logic [4:0] t;

  always_comb begin
    t = {1'b0, x} + {1'b0, y} + {4'b0000, cin};
    if (t > {1'b0, BCD_MAX}) begin
      // Only the low nibble of t+6 is kept, so a 4-bit add is enough.
      digit = t[3:0] + BCD_ADJ;
      cout  = 1'b1;
    end else begin
      digit = t[3:0];
      cout  = 1'b0;
    end
  end

endmodule

// File: rtl/iiitb_bcd_seq.sv
// Multi-digit BCD adder sequencer: ripples one digit per clock, LSD first, through a shared adder.
// Optional define BCD_INVALID_CHECK_EN: flag operands containing digits above 9 on err.
module iiitb_bcd_seq
  import iiitb_bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_valid,
  output logic                  start_ready,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  carry_in,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  carry,
  output logic                  done_valid,
  input  logic                  done_ready,
  output logic                  busy,
  output logic                  err
);

  localparam int unsigned W    = 4 * DIGITS;
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DIGITS - 1);

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [IdxW+1:0] bit_base;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            c_q, c_d;
  logic            carry_q, carry_d;
  logic            done_valid_q;
  logic            busy_q;
  logic            accept;
  logic            done_entry;
  logic [3:0]      x_dig;
  logic [3:0]      y_dig;
  logic [3:0]      dig_out;
  logic            dig_cout;

  assign accept     = (state_q == StIdle) && start_valid;
  assign done_entry = (state_q == StAdd) && (idx_q == LastIdx);

  // Bit offset of the current digit within the packed operands.
  assign bit_base = {idx_q, 2'b00};
  assign x_dig    = a_q[bit_base +: 4];
  assign y_dig    = b_q[bit_base +: 4];

  bcd_digit_add u_digit_add (
    .x     (x_dig),
    .y     (y_dig),
    .cin   (c_q),
    .digit (dig_out),
    .cout  (dig_cout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          a_d     = a;
          b_d     = b;
          c_d     = carry_in;
          idx_d   = '0;
          acc_d   = '0;
          state_d = StAdd;
        end
      end
      StAdd: begin
        acc_d[bit_base +: 4] = dig_out;
        c_d                  = dig_cout;
        if (done_entry) begin
          // Outputs are only ever loaded here, so they hold through DONE and IDLE.
          sum_d   = acc_d;
          carry_d = dig_cout;
          idx_d   = '0;
          state_d = StDone;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      StDone: begin
        if (done_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      c_q          <= 1'b0;
      acc_q        <= '0;
      sum_q        <= '0;
      carry_q      <= 1'b0;
      done_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      a_q          <= a_d;
      b_q          <= b_d;
      c_q          <= c_d;
      acc_q        <= acc_d;
      sum_q        <= sum_d;
      carry_q      <= carry_d;
      done_valid_q <= (state_d == StDone);
      busy_q       <= (state_d != StIdle);
    end
  end

`ifdef BCD_INVALID_CHECK_EN
  logic any_invalid;
  logic flag_q, flag_d;
  logic err_q, err_d;

  always_comb begin
    any_invalid = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (!is_bcd(a[4*i +: 4]) || !is_bcd(b[4*i +: 4])) begin
        any_invalid = 1'b1;
      end
    end
  end

  // The flag is per transaction: each acceptance overwrites it.
  always_comb begin
    flag_d = flag_q;
    err_d  = err_q;
    if (accept) begin
      flag_d = any_invalid;
    end
    if (done_entry) begin
      err_d = flag_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flag_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      flag_q <= flag_d;
      err_q  <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign start_ready = (state_q == StIdle);
  assign sum         = sum_q;
  assign carry       = carry_q;
  assign done_valid  = done_valid_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_iiitb_bcd_seq.sv
// Scoreboard bench for iiitb_bcd_seq: driver pushes model results, negedge monitor pops and compares.
module tb_iiitb_bcd_seq;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned W      = 4 * DIGITS;

  typedef struct {
    logic [W-1:0] sum;
    logic         carry;
    logic         err;
    int           acc_cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         carry_in;
  logic [W-1:0] sum;
  logic         carry;
  logic         done_valid;
  logic         done_ready;
  logic         busy;
  logic         err;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t exp_q[$];
  exp_t cur;
  logic have_cur = 1'b0;
  logic dv_prev  = 1'b0;
  logic mon_en   = 1'b0;

  iiitb_bcd_seq #(.DIGITS(DIGITS)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .carry_in    (carry_in),
    .sum         (sum),
    .carry       (carry),
    .done_valid  (done_valid),
    .done_ready  (done_ready),
    .busy        (busy),
    .err         (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain decimal arithmetic when every digit is BCD; otherwise apply the
  // per-digit "above 9 add 6, carry 1" rule literally.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    exp_t         e;
    bit           all_bcd = 1'b1;
    longint       dx = 0, dy = 0, s, scale = 1;
    int           c, t;
    logic [W-1:0] tmp;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      tmp = x >> (4 * i);
      if (tmp[3:0] > 9) all_bcd = 1'b0;
      dx = dx * 10 + longint'(tmp[3:0]);
      tmp = y >> (4 * i);
      if (tmp[3:0] > 9) all_bcd = 1'b0;
      dy = dy * 10 + longint'(tmp[3:0]);
      scale = scale * 10;
    end
    e.sum = '0;
    if (all_bcd) begin
      s       = dx + dy + longint'(ci);
      e.carry = (s >= scale);
      s       = s % scale;
      for (int i = 0; i < DIGITS; i++) begin
        e.sum = e.sum | (W'(s % 10) << (4 * i));
        s     = s / 10;
      end
    end else begin
      c = int'(ci);
      for (int i = 0; i < DIGITS; i++) begin
        t = int'((x >> (4 * i)) & W'(15)) + int'((y >> (4 * i)) & W'(15)) + c;
        if (t > 9) begin
          t = (t + 6) % 16;
          c = 1;
        end else begin
          c = 0;
        end
        e.sum = e.sum | (W'(t) << (4 * i));
      end
      e.carry = c[0];
    end
`ifdef BCD_INVALID_CHECK_EN
    e.err = !all_bcd;
`else
    e.err = 1'b0;
`endif
    e.acc_cyc = 0;
    return e;
  endfunction

  function automatic logic [W-1:0] rand_operand(input bit allow_bad);
    logic [W-1:0] v = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (allow_bad && ($urandom_range(0, 3) == 0)) v = v | (W'($urandom_range(10, 15)) << (4 * i));
      else                                          v = v | (W'($urandom_range(0, 9)) << (4 * i));
    end
    return v;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (done_valid && !dv_prev) begin
        if (exp_q.size() == 0) begin
          check("spurious_done_valid", 64'(done_valid), 64'd0);
        end else begin
          cur      = exp_q.pop_front();
          have_cur = 1'b1;
          check("sum", 64'(sum), 64'(cur.sum));
          check("carry", 64'(carry), 64'(cur.carry));
          check("err", 64'(err), 64'(cur.err));
          check("latency", 64'(cyc - cur.acc_cyc), 64'(DIGITS + 1));
          check("busy_in_done", 64'(busy), 64'd1);
          check("start_ready_in_done", 64'(start_ready), 64'd0);
        end
      end else if (done_valid && have_cur) begin
        check("sum_stable", 64'(sum), 64'(cur.sum));
        check("carry_stable", 64'(carry), 64'(cur.carry));
        check("err_stable", 64'(err), 64'(cur.err));
      end
      dv_prev <= done_valid;
    end else begin
      dv_prev <= 1'b0;
    end
  end

  // Present operands, wait for acceptance, scramble inputs, then consume the result after hold cycles.
  task automatic run_txn(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                         input int hold);
    exp_t e;
    bit   seen;
    @(negedge clk);
    a = ta; b = tb; carry_in = tc; start_valid = 1'b1;
    for (int k = 0; k < 40 && !start_ready; k++) @(negedge clk);
    if (!start_ready) begin
      check("accept_timeout", 64'(start_ready), 64'd1);
      start_valid = 1'b0;
      return;
    end
    e         = model(ta, tb, tc);
    e.acc_cyc = cyc;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); carry_in = 1'($urandom);
    seen = 1'b0;
    for (int k = 0; k < DIGITS + 10 && !seen; k++) begin
      @(negedge clk);
      seen = done_valid;
    end
    if (!seen) begin
      check("done_timeout", 64'(done_valid), 64'd1);
      return;
    end
    repeat (hold) @(negedge clk);
    done_ready = 1'b1;
    @(posedge clk);
    #1;
    done_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    bit   seen;
    rst = 1'b1; start_valid = 1'b0; done_ready = 1'b0;
    a = '0; b = '0; carry_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_carry", 64'(carry), 64'd0);
    check("rst_done_valid", 64'(done_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_start_ready", 64'(start_ready), 64'd1);
    mon_en = 1'b1;

    run_txn(16'h1234, 16'h5678, 1'b0, 0);
    run_txn(16'h0999, 16'h0001, 1'b0, 1);
    run_txn(16'hFFFF, 16'hFFFF, 1'b1, 0);
    run_txn(16'h00A0, 16'h0000, 1'b0, 0);
    run_txn(16'h9999, 16'h0000, 1'b1, 2);

    // Reset during the second ADD cycle aborts the transaction.
    @(negedge clk);
    a = 16'h4321; b = 16'h1111; carry_in = 1'b0; start_valid = 1'b1;
    check("abort_start_ready", 64'(start_ready), 64'd1);
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_start_ready_after", 64'(start_ready), 64'd1);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_sum", 64'(sum), 64'd0);
    check("abort_carry", 64'(carry), 64'd0);
    check("abort_err", 64'(err), 64'd0);
    for (int k = 0; k < DIGITS + 3; k++) begin
      check("abort_no_done", 64'(done_valid), 64'd0);
      @(negedge clk);
    end

    // Back-pressure with start_valid held high the whole time.
    a = 16'h2718; b = 16'h3141; carry_in = 1'b1; start_valid = 1'b1;
    check("hold_start_ready", 64'(start_ready), 64'd1);
    e         = model(16'h2718, 16'h3141, 1'b1);
    e.acc_cyc = cyc;
    exp_q.push_back(e);
    seen = 1'b0;
    for (int k = 0; k < DIGITS + 10 && !seen; k++) begin
      @(negedge clk);
      seen = done_valid;
    end
    check("hold_done_seen", 64'(seen), 64'd1);
    for (int k = 0; k < 5; k++) begin
      check("hold_done_valid", 64'(done_valid), 64'd1);
      check("hold_start_ready_low", 64'(start_ready), 64'd0);
      @(negedge clk);
    end
    done_ready = 1'b1;
    @(posedge clk);
    #1;
    done_ready = 1'b0;
    @(negedge clk);
    check("hold_idle_start_ready", 64'(start_ready), 64'd1);
    check("hold_idle_done_valid", 64'(done_valid), 64'd0);
    check("hold_idle_busy", 64'(busy), 64'd0);
    check("hold_idle_sum_kept", 64'(sum), 64'(e.sum));
    check("hold_idle_carry_kept", 64'(carry), 64'(e.carry));
    // start_valid is still high, so the next edge accepts the same operands again.
    e.acc_cyc = cyc;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < DIGITS + 10 && !seen; k++) begin
      @(negedge clk);
      seen = done_valid;
    end
    check("hold_second_done_seen", 64'(seen), 64'd1);
    done_ready = 1'b1;
    @(posedge clk);
    #1;
    done_ready = 1'b0;

    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_txn(rand_operand(n % 4 == 3), rand_operand(n % 5 == 4), 1'($urandom), $urandom_range(0, 3));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
